// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter.
//   arb_state_t : arbiter FSM states (IDLE -> ISSUE -> WAIT -> RESP).
//   REQ_CPU     : requester 0, the CPU (fetch/load/store).
//   REQ_LOADER  : requester 1, the program loader / debug port.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

    localparam logic REQ_CPU    = 1'b0;
    localparam logic REQ_LOADER = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational winner selection for the two-requester memory arbiter.
// Ports:
//   req0, req1  : pending requests from CPU and loader
//   last_grant  : requester granted most recently
//   valid       : at least one request pending
//   winner      : requester to grant when valid
// With FIXED_PRIO != 0 the CPU wins every tie; otherwise a tie goes to the
// requester that was not granted last. A lone requester always wins.
module rr_picker
    import mem_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = req0 | req1;
        winner = REQ_CPU;
        if (req0 && req1) begin
            winner = (FIXED_PRIO != 0) ? REQ_CPU : ~last_grant;
        end else if (req1) begin
            winner = REQ_LOADER;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the CPU (requester 0) and the program
// loader / debug port (requester 1) with a req/ack handshake. Exactly one
// access is in flight at a time; every output is registered.
// Ports:
//   clk, reset             : clock and synchronous active-high reset
//   req0/we0/addr0/wdata0  : CPU request (held until ack0)
//   ack0                   : one-cycle completion pulse to the CPU
//   req1/we1/addr1/wdata1  : loader request (held until ack1)
//   ack1                   : one-cycle completion pulse to the loader
//   rdata                  : read data, valid in the ack cycle, held until next read
//   grant_id               : requester owning the current or last access
//   busy                   : high whenever the FSM is not idle
//   mem_addr/mem_wdata     : address and write data to the memory
//   mem_write              : memory write strobe (one cycle, during ISSUE)
//   mem_rdata              : memory read data, valid MEM_LATENCY cycles after address
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int BITS_DATA   = 32,
    parameter int BITS_ADDR   = 16,
    parameter int MEM_LATENCY = 1,
    parameter int FIXED_PRIO  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 we0,
    input  logic [BITS_ADDR-1:0] addr0,
    input  logic [BITS_DATA-1:0] wdata0,
    output logic                 ack0,
    input  logic                 req1,
    input  logic                 we1,
    input  logic [BITS_ADDR-1:0] addr1,
    input  logic [BITS_DATA-1:0] wdata1,
    output logic                 ack1,
    output logic [BITS_DATA-1:0] rdata,
    output logic                 grant_id,
    output logic                 busy,
    output logic [BITS_ADDR-1:0] mem_addr,
    output logic [BITS_DATA-1:0] mem_wdata,
    output logic                 mem_write,
    input  logic [BITS_DATA-1:0] mem_rdata
);

    // Counter only needs to hold MEM_LATENCY-1; keep at least one bit.
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    arb_state_t           state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic                 last_grant, last_grant_next;
    logic                 is_write, is_write_next;
    logic                 ack0_next, ack1_next;
    logic [BITS_DATA-1:0] rdata_next;
    logic                 grant_id_next;
    logic                 busy_next;
    logic [BITS_ADDR-1:0] mem_addr_next;
    logic [BITS_DATA-1:0] mem_wdata_next;
    logic                 mem_write_next;

    logic pick_valid;
    logic pick_id;

    rr_picker #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_picker (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .winner     (pick_id)
    );

    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        last_grant_next = last_grant;
        is_write_next   = is_write;
        grant_id_next   = grant_id;
        rdata_next      = rdata;
        mem_addr_next   = mem_addr;
        mem_wdata_next  = mem_wdata;
        // Strobe and acks are single-cycle pulses: low unless set below.
        mem_write_next  = 1'b0;
        ack0_next       = 1'b0;
        ack1_next       = 1'b0;

        unique case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_next      = ARB_ISSUE;
                    grant_id_next   = pick_id;
                    last_grant_next = pick_id;
                    if (pick_id == REQ_LOADER) begin
                        mem_addr_next  = addr1;
                        mem_wdata_next = wdata1;
                        mem_write_next = we1;
                        is_write_next  = we1;
                    end else begin
                        mem_addr_next  = addr0;
                        mem_wdata_next = wdata0;
                        mem_write_next = we0;
                        is_write_next  = we0;
                    end
                end
            end
            ARB_ISSUE: begin
                cnt_next   = CNT_W'(MEM_LATENCY - 1);
                state_next = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (cnt == '0) begin
                    // Writes leave the last read value on rdata.
                    if (!is_write) begin
                        rdata_next = mem_rdata;
                    end
                    ack0_next  = (grant_id == REQ_CPU);
                    ack1_next  = (grant_id == REQ_LOADER);
                    state_next = ARB_RESP;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ARB_RESP: begin
                state_next = ARB_IDLE;
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase

        busy_next = (state_next != ARB_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            cnt        <= '0;
            // CPU wins the first tie after reset.
            last_grant <= REQ_LOADER;
            is_write   <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata      <= '0;
            grant_id   <= 1'b0;
            busy       <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_write  <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            last_grant <= last_grant_next;
            is_write   <= is_write_next;
            ack0       <= ack0_next;
            ack1       <= ack1_next;
            rdata      <= rdata_next;
            grant_id   <= grant_id_next;
            busy       <= busy_next;
            mem_addr   <= mem_addr_next;
            mem_wdata  <= mem_wdata_next;
            mem_write  <= mem_write_next;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance a is round-robin with MEM_LATENCY 1,
// instance b is fixed-priority with MEM_LATENCY 3. Each has a small memory
// model and a scoreboard of expected (requester, rdata) per ack.
module tb_mem_arbiter;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic id, input logic [31:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        return e;
    endfunction

    // ---------------- instance a: round-robin, latency 1 ----------------
    logic        rst_a;
    logic        req0_a, we0_a, ack0_a, req1_a, we1_a, ack1_a;
    logic [15:0] addr0_a, addr1_a, ma_a;
    logic [31:0] wdata0_a, wdata1_a, rdata_a, mwd_a, mrd_a;
    logic        gid_a, busy_a, mw_a;

    mem_arbiter #(.BITS_DATA(32), .BITS_ADDR(16), .MEM_LATENCY(1), .FIXED_PRIO(0)) u_a (
        .clk(clk), .reset(rst_a),
        .req0(req0_a), .we0(we0_a), .addr0(addr0_a), .wdata0(wdata0_a), .ack0(ack0_a),
        .req1(req1_a), .we1(we1_a), .addr1(addr1_a), .wdata1(wdata1_a), .ack1(ack1_a),
        .rdata(rdata_a), .grant_id(gid_a), .busy(busy_a),
        .mem_addr(ma_a), .mem_wdata(mwd_a), .mem_write(mw_a), .mem_rdata(mrd_a)
    );

    logic [31:0] mem_a [0:255];
    always @(posedge clk) begin
        if (mw_a) mem_a[ma_a[7:0]] <= mwd_a;
        mrd_a <= mem_a[ma_a[7:0]];
    end

    // ---------------- instance b: fixed priority, latency 3 -------------
    logic        rst_b;
    logic        req0_b, we0_b, ack0_b, req1_b, we1_b, ack1_b;
    logic [15:0] addr0_b, addr1_b, ma_b;
    logic [31:0] wdata0_b, wdata1_b, rdata_b, mwd_b, mrd_b;
    logic        gid_b, busy_b, mw_b;
    logic [31:0] pipe_b [0:2];

    mem_arbiter #(.BITS_DATA(32), .BITS_ADDR(16), .MEM_LATENCY(3), .FIXED_PRIO(1)) u_b (
        .clk(clk), .reset(rst_b),
        .req0(req0_b), .we0(we0_b), .addr0(addr0_b), .wdata0(wdata0_b), .ack0(ack0_b),
        .req1(req1_b), .we1(we1_b), .addr1(addr1_b), .wdata1(wdata1_b), .ack1(ack1_b),
        .rdata(rdata_b), .grant_id(gid_b), .busy(busy_b),
        .mem_addr(ma_b), .mem_wdata(mwd_b), .mem_write(mw_b), .mem_rdata(mrd_b)
    );

    logic [31:0] mem_b [0:255];
    always @(posedge clk) begin
        if (mw_b) mem_b[ma_b[7:0]] <= mwd_b;
        pipe_b[0] <= mem_b[ma_b[7:0]];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign mrd_b = pipe_b[2];

    // ---------------- scoreboards / monitors ----------------
    exp_t sb_a[$];
    exp_t sb_b[$];
    int          wcnt_a = 0;
    logic [15:0] waddr_a;
    logic [31:0] wdat_a;

    always @(negedge clk) begin
        if (mw_a) begin
            wcnt_a  = wcnt_a + 1;
            waddr_a = ma_a;
            wdat_a  = mwd_a;
        end
        if (ack0_a || ack1_a) begin
            exp_t e;
            check("a_ack_onehot", ack0_a & ack1_a, 1'b0);
            check("a_busy_at_ack", busy_a, 1'b1);
            check("a_sb_nonempty", sb_a.size() != 0, 1'b1);
            if (sb_a.size() != 0) begin
                e = sb_a.pop_front();
                check("a_ack_id", ack1_a, e.id);
                check("a_grant_id", gid_a, e.id);
                check("a_rdata", rdata_a, e.data);
            end
        end
    end

    always @(negedge clk) begin
        if (ack0_b || ack1_b) begin
            exp_t e;
            check("b_ack_onehot", ack0_b & ack1_b, 1'b0);
            check("b_sb_nonempty", sb_b.size() != 0, 1'b1);
            if (sb_b.size() != 0) begin
                e = sb_b.pop_front();
                check("b_ack_id", ack1_b, e.id);
                check("b_grant_id", gid_b, e.id);
                check("b_rdata", rdata_b, e.data);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for 'want' acks on instance dut; lat = edges to first ack.
    task automatic wait_acks(input int dut, input int want, output int seen, output int lat);
        int cyc;
        cyc  = 0;
        seen = 0;
        lat  = -1;
        while (seen < want && cyc < 80) begin
            @(posedge clk);
            #1;
            cyc++;
            if (dut == 0 ? (ack0_a | ack1_a) : (ack0_b | ack1_b)) begin
                seen++;
                if (lat < 0) lat = cyc;
            end
        end
    endtask

    initial begin
        int seen, lat, w0;

        rst_a = 1'b1; rst_b = 1'b1;
        req0_a = 0; we0_a = 0; addr0_a = '0; wdata0_a = '0;
        req1_a = 0; we1_a = 0; addr1_a = '0; wdata1_a = '0;
        req0_b = 0; we0_b = 0; addr0_b = '0; wdata0_b = '0;
        req1_b = 0; we1_b = 0; addr1_b = '0; wdata1_b = '0;
        mem_a[8'h00] <= 32'h0;
        mem_a[8'h10] <= 32'hDEADBEEF;
        mem_a[8'h20] <= 32'hA0A0A0A0;
        mem_a[8'h30] <= 32'hB1B1B1B1;
        mem_a[8'hFF] <= 32'h0;
        mem_b[8'h00] <= 32'h11111111;
        mem_b[8'h40] <= 32'hCAFEF00D;
        mem_b[8'h50] <= 32'h55AA55AA;
        tick(3);

        check("a_reset_ctl", {ack0_a, ack1_a, gid_a, busy_a, mw_a}, 5'b0);
        check("a_reset_addr", ma_a, 16'h0);
        check("a_reset_wdata", mwd_a, 32'h0);
        check("a_reset_rdata", rdata_a, 32'h0);
        check("b_reset_ctl", {ack0_b, ack1_b, gid_b, busy_b, mw_b}, 5'b0);
        check("b_reset_rdata", rdata_b, 32'h0);
        rst_a = 1'b0; rst_b = 1'b0;
        tick(1);

        // single read, requester 0
        req0_a = 1; we0_a = 0; addr0_a = 16'h0010;
        sb_a.push_back(mk(1'b0, 32'hDEADBEEF));
        wait_acks(0, 1, seen, lat);
        check("rd_ack_count", seen, 1);
        check("rd_latency", lat, 3);
        check("rd_mem_addr", ma_a, 16'h0010);
        tick(1);
        req0_a = 0;
        tick(1);
        check("rd_no_reserve", busy_a, 1'b0);

        // single write, requester 1
        w0 = wcnt_a;
        req1_a = 1; we1_a = 1; addr1_a = 16'h00FF; wdata1_a = 32'h12345678;
        sb_a.push_back(mk(1'b1, 32'hDEADBEEF));
        wait_acks(0, 1, seen, lat);
        check("wr_ack_count", seen, 1);
        check("wr_latency", lat, 3);
        check("wr_strobe_cycles", wcnt_a - w0, 1);
        check("wr_strobe_addr", waddr_a, 16'h00FF);
        check("wr_strobe_data", wdat_a, 32'h12345678);
        check("wr_hold_addr", ma_a, 16'h00FF);
        tick(1);
        req1_a = 0; we1_a = 0;
        check("idle_hold_wdata", mwd_a, 32'h12345678);

        // read back the written word
        req0_a = 1; we0_a = 0; addr0_a = 16'h00FF;
        sb_a.push_back(mk(1'b0, 32'h12345678));
        wait_acks(0, 1, seen, lat);
        check("rb_ack_count", seen, 1);
        tick(1);
        req0_a = 0;

        // simultaneous held requests, round-robin 0,1,0,1 from reset
        rst_a = 1; tick(1); rst_a = 0;
        req0_a = 1; addr0_a = 16'h0020; req1_a = 1; addr1_a = 16'h0030; we1_a = 0;
        sb_a.push_back(mk(1'b0, 32'hA0A0A0A0));
        sb_a.push_back(mk(1'b1, 32'hB1B1B1B1));
        sb_a.push_back(mk(1'b0, 32'hA0A0A0A0));
        sb_a.push_back(mk(1'b1, 32'hB1B1B1B1));
        wait_acks(0, 4, seen, lat);
        check("rr_ack_count", seen, 4);
        check("rr_first_latency", lat, 3);
        tick(1);
        req0_a = 0; req1_a = 0;
        tick(1);

        // reset during WAIT; requester 0 must win the first tie afterwards
        req0_a = 1; req1_a = 1;
        tick(2);
        check("rst_busy_before", busy_a, 1'b1);
        rst_a = 1;
        tick(1);
        check("rst_busy", busy_a, 1'b0);
        check("rst_acks", {ack0_a, ack1_a}, 2'b00);
        check("rst_mem_write", mw_a, 1'b0);
        rst_a = 0;
        sb_a.push_back(mk(1'b0, 32'hA0A0A0A0));
        sb_a.push_back(mk(1'b1, 32'hB1B1B1B1));
        wait_acks(0, 2, seen, lat);
        check("rst_reserve_count", seen, 2);
        check("rst_reserve_latency", lat, 3);
        tick(1);
        req0_a = 0; req1_a = 0;

        // latency-3 read on instance b
        req0_b = 1; we0_b = 0; addr0_b = 16'h0040;
        sb_b.push_back(mk(1'b0, 32'hCAFEF00D));
        wait_acks(1, 1, seen, lat);
        check("l3_ack_count", seen, 1);
        check("l3_latency", lat, 5);
        tick(1);
        req0_b = 0;
        tick(1);

        // fixed priority: requester 1 only once req0 is low in IDLE
        req0_b = 1; addr0_b = 16'h0040; req1_b = 1; we1_b = 0; addr1_b = 16'h0050;
        sb_b.push_back(mk(1'b0, 32'hCAFEF00D));
        sb_b.push_back(mk(1'b0, 32'hCAFEF00D));
        sb_b.push_back(mk(1'b0, 32'hCAFEF00D));
        wait_acks(1, 3, seen, lat);
        check("fp_cpu_count", seen, 3);
        tick(1);
        req0_b = 0;
        sb_b.push_back(mk(1'b1, 32'h55AA55AA));
        wait_acks(1, 1, seen, lat);
        check("fp_loader_count", seen, 1);
        check("fp_loader_latency", lat, 5);
        tick(1);
        req1_b = 0;

        tick(4);
        check("a_sb_drained", sb_a.size(), 0);
        check("b_sb_drained", sb_b.size(), 0);
        check("a_idle_end", busy_a, 1'b0);
        check("b_idle_end", busy_b, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
